baud_tick_gen: RTL and testbench

Parametrised successor to the SPART baud rate generator. It divides clk into a sample_tick enable at OVS times the bit rate, and a bit_tick enable once every OVS sample ticks. It adds a fractional divisor, atomic 16-bit divisor update, an enable bit, readback, and a resync input so a receiver can align bit_tick to mid-bit on start-bit detect. It sits between the SPART bus interface and the TX/RX shift engines.

---
 rtl/baud_tick_gen.sv | 138 +++++++++++++
 tb/tb_baud_tick_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// Baud tick generator: fractional clock divider producing oversample and bit-rate
// enables, with an atomically updated divisor, an enable bit, register readback,
// and a resync input that aligns the bit phase to mid-bit.
module baud_tick_gen #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned RST_DIV  = 325,
    parameter int unsigned RST_FRAC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic [7:0]       rd_data,
    input  logic             resync,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic [DIV_W-1:0] div_active
);

    localparam int unsigned OS_W = (OVS > 2) ? $clog2(OVS) : 1;

    localparam logic [1:0] A_DIV_LO = 2'b00;
    localparam logic [1:0] A_DIV_HI = 2'b01;
    localparam logic [1:0] A_FRAC   = 2'b10;
    localparam logic [1:0] A_CTRL   = 2'b11;

    logic [7:0]        lo_stage, lo_nxt;
    logic [DIV_W-1:0]  div_reg, div_nxt;
    logic [FRAC_W-1:0] frac_reg, frac_nxt;
    logic              en, en_nxt;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [FRAC_W-1:0] acc, acc_nxt;
    logic [OS_W-1:0]   os_cnt, os_nxt;

    logic [15:0]       hi_cat;
    logic              div_hi_wr;
    logic [DIV_W-1:0]  n_cur, n_new;
    logic [FRAC_W:0]   acc_sum;
    logic              tick_c;

    // Tick enables are decoded straight from the counter state.
    assign tick_c      = en & (cnt == '0) & ~rst;
    assign sample_tick = tick_c;
    assign bit_tick    = tick_c & (os_cnt == OS_W'(OVS - 1));
    assign div_active  = div_reg;

    // Register readback of the active configuration (not the low-byte staging register).
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_DIV_LO: rd_data = div_reg[7:0];
            A_DIV_HI: rd_data = 8'(div_reg >> 8);
            A_FRAC:   rd_data = 8'(frac_reg);
            default:  rd_data = {7'b0, en};
        endcase
    end

    // Next-state for configuration registers and the divider phase.
    always_comb begin
        lo_nxt    = lo_stage;
        div_nxt   = div_reg;
        frac_nxt  = frac_reg;
        en_nxt    = en;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        os_nxt    = os_cnt;
        div_hi_wr = 1'b0;
        hi_cat    = {wr_data, lo_stage};

        if (wr_en) begin
            case (addr)
                A_DIV_LO: lo_nxt = wr_data;
                A_DIV_HI: begin
                    div_nxt   = hi_cat[DIV_W-1:0];
                    div_hi_wr = 1'b1;
                end
                A_FRAC:   frac_nxt = wr_data[FRAC_W-1:0];
                default:  en_nxt = wr_data[0];
            endcase
        end

        // A zero divisor behaves as one: a tick every cycle.
        n_cur   = (div_reg == '0) ? DIV_W'(1) : div_reg;
        n_new   = (div_nxt == '0) ? DIV_W'(1) : div_nxt;
        acc_sum = {1'b0, acc} + {1'b0, frac_reg};

        if (!en_nxt || !en) begin
            // Disabled, or just enabled: park the phase at the start of a period.
            cnt_nxt = n_new - DIV_W'(1);
            acc_nxt = '0;
            os_nxt  = '0;
        end else begin
            if (cnt != '0) begin
                cnt_nxt = cnt - DIV_W'(1);
            end else begin
                // Fractional carry stretches the next period by one cycle.
                cnt_nxt = n_cur - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
                acc_nxt = acc_sum[FRAC_W-1:0];
                os_nxt  = os_cnt + OS_W'(1);
            end
            if (div_hi_wr) begin
                cnt_nxt = n_new - DIV_W'(1);
                acc_nxt = '0;
                os_nxt  = '0;
            end
            if (resync) begin
                cnt_nxt = n_new - DIV_W'(1);
                acc_nxt = '0;
                os_nxt  = OS_W'(OVS / 2);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_stage <= 8'(RST_DIV);
            div_reg  <= DIV_W'(RST_DIV);
            frac_reg <= FRAC_W'(RST_FRAC);
            en       <= 1'b1;
            cnt      <= DIV_W'(RST_DIV - 1);
            acc      <= '0;
            os_cnt   <= '0;
        end else begin
            lo_stage <= lo_nxt;
            div_reg  <= div_nxt;
            frac_reg <= frac_nxt;
            en       <= en_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            os_cnt   <= os_nxt;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: absolute-time tick schedule model,
// register readback table, directed corner sequences and randomized traffic.
module tb_baud_tick_gen;

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned FRAC_W   = 4;
    localparam int unsigned OVS      = 16;
    localparam int unsigned RST_DIV  = 325;
    localparam int unsigned RST_FRAC = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       addr = 2'b00;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             resync = 1'b0;
    logic [7:0]       rd_data;
    logic             sample_tick;
    logic             bit_tick;
    logic [DIV_W-1:0] div_active;

    baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
        .RST_DIV(RST_DIV), .RST_FRAC(RST_FRAC)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_data(rd_data), .resync(resync), .sample_tick(sample_tick),
        .bit_tick(bit_tick), .div_active(div_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: configuration plus the absolute cycle of the next sample tick.
    longint      cyc = 0;
    longint      m_next = 0;
    int unsigned m_lo, m_div, m_frac, m_en, m_fsum, m_ticks;

    longint last_bit_cyc = -1;
    longint exp_bper = 0;
    logic   seen_bit = 1'b0;

    typedef struct {
        logic [1:0] a;
        logic       we;
        logic [7:0] wd;
        logic       rs;
        int         exp_rd;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int unsigned nval(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_lo    = RST_DIV % 256;
        m_div   = RST_DIV;
        m_frac  = RST_FRAC;
        m_en    = 1;
        m_fsum  = 0;
        m_ticks = 0;
        m_next  = cyc + RST_DIV - 1;
    endtask

    // Restart issued in cycle cyc: first tick N-1 edges after the next edge.
    task automatic restart(input int unsigned n, input int unsigned t0);
        m_next  = cyc + longint'(n);
        m_fsum  = 0;
        m_ticks = t0;
    endtask

    task automatic step(input logic [1:0] a, input logic we, input logic [7:0] wd,
                        input logic rs, input int exp_rd);
        bit          e_tick, e_bit, extra;
        int unsigned e_rd, n, old_en;
        addr = a; wr_en = we; wr_data = wd; resync = rs;
        #1;
        e_tick = (m_en != 0) && (cyc == m_next);
        e_bit  = e_tick && ((m_ticks % OVS) == OVS - 1);
        case (a)
            2'd0:    e_rd = m_div % 256;
            2'd1:    e_rd = (m_div / 256) % 256;
            2'd2:    e_rd = m_frac;
            default: e_rd = m_en;
        endcase
        chk("sample_tick", longint'(sample_tick), longint'(e_tick));
        chk("bit_tick", longint'(bit_tick), longint'(e_bit));
        chk("div_active", longint'(div_active), longint'(m_div));
        chk("rd_data", longint'(rd_data), longint'(e_rd));
        if (exp_rd >= 0) chk("rd_table", longint'(rd_data), longint'(exp_rd));
        seen_bit = bit_tick;
        if (bit_tick) begin
            if (exp_bper != 0 && last_bit_cyc >= 0)
                chk("bit_period", cyc - last_bit_cyc, exp_bper);
            last_bit_cyc = cyc;
        end
        @(posedge clk);
        n = nval(m_div);
        if (e_tick) begin
            m_fsum = m_fsum + m_frac;
            extra  = (m_fsum >= (1 << FRAC_W));
            if (extra) m_fsum = m_fsum - (1 << FRAC_W);
            m_next  = cyc + longint'(n) + (extra ? 1 : 0);
            m_ticks = m_ticks + 1;
        end
        old_en = m_en;
        if (we) begin
            case (a)
                2'd0:    m_lo = int'(wd);
                2'd1:    m_div = (int'(wd) * 256 + m_lo) % (1 << DIV_W);
                2'd2:    m_frac = int'(wd) % (1 << FRAC_W);
                default: m_en = int'(wd[0]);
            endcase
        end
        if (m_en != 0) begin
            if (old_en == 0)        restart(nval(m_div), 0);
            else if (we && a == 1)  restart(nval(m_div), rs ? OVS / 2 : 0);
            else if (rs)            restart(nval(m_div), OVS / 2);
        end
        cyc++;
        #1;
        wr_en = 1'b0; resync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0, -1);
    endtask

    // Hold reset for n cycles, checking quiet ticks and reset readback.
    task automatic rst_pulse(input int n);
        int rd_rst [4];
        rd_rst[0] = RST_DIV % 256; rd_rst[1] = RST_DIV / 256;
        rd_rst[2] = RST_FRAC;      rd_rst[3] = 1;
        wr_en = 1'b0; resync = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            addr = 2'(i % 4);
            #1;
            chk("tick_in_rst", longint'(sample_tick), 0);
            chk("bit_in_rst", longint'(bit_tick), 0);
            chk("div_in_rst", longint'(div_active), RST_DIV);
            chk("rd_in_rst", longint'(rd_data), longint'(rd_rst[i % 4]));
            @(posedge clk);
            cyc++;
            #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vec_t   tbl [6];
        longint rs_cyc;
        bit     found;
        logic [1:0] ra;
        logic [7:0] rwd;
        logic       rwe, rrs;

        #1;
        rst_pulse(4);

        // Defaults: 325.5-cycle sample period, 5208-cycle bit period.
        exp_bper = 5208; last_bit_cyc = -1;
        idle(20000);

        // Atomic divisor update to 10 with FRAC=0.
        exp_bper = 0;
        step(2'd2, 1'b1, 8'h00, 1'b0, -1);
        idle(7);
        step(2'd0, 1'b1, 8'h0A, 1'b0, -1);
        idle(5);
        chk("div_before_hi", longint'(div_active), RST_DIV);
        step(2'd1, 1'b1, 8'h00, 1'b0, -1);
        chk("div_after_hi", longint'(div_active), 10);
        exp_bper = 160; last_bit_cyc = cyc - 1;
        idle(500);

        // Zero divisor: tick every cycle, readback table.
        exp_bper = 0; last_bit_cyc = -1;
        tbl[0] = '{2'd0, 1'b1, 8'h00, 1'b0, -1};
        tbl[1] = '{2'd1, 1'b1, 8'h00, 1'b0, -1};
        tbl[2] = '{2'd0, 1'b0, 8'h00, 1'b0, 0};
        tbl[3] = '{2'd1, 1'b0, 8'h00, 1'b0, 0};
        tbl[4] = '{2'd2, 1'b0, 8'h00, 1'b0, 0};
        tbl[5] = '{2'd3, 1'b0, 8'h00, 1'b0, 1};
        for (int i = 0; i < 6; i++) step(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].rs, tbl[i].exp_rd);
        exp_bper = 16;
        idle(64);

        // Disable mid-period, then re-enable at N=10.
        exp_bper = 0;
        step(2'd0, 1'b1, 8'h0A, 1'b0, -1);
        step(2'd1, 1'b1, 8'h00, 1'b0, -1);
        idle(25);
        step(2'd3, 1'b1, 8'h00, 1'b0, -1);
        step(2'd3, 1'b0, 8'h00, 1'b0, 0);
        idle(30);
        step(2'd3, 1'b1, 8'h01, 1'b0, -1);
        exp_bper = 160; last_bit_cyc = cyc - 1;
        idle(400);

        // Resync: bit tick 8 sample ticks (80 cycles) after the pulse.
        exp_bper = 0; last_bit_cyc = -1;
        rs_cyc = cyc;
        step(2'd0, 1'b0, 8'h00, 1'b1, -1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(2'd3, 1'b0, 8'h00, 1'b0, -1);
            if (seen_bit) begin
                found = 1'b1;
                chk("resync_to_bit", last_bit_cyc - rs_cyc, 80);
            end
        end
        if (!found) chk("resync_timeout", 0, 1);
        exp_bper = 160;
        idle(400);

        // Reset mid-period restores defaults.
        exp_bper = 0;
        idle(33);
        rst_pulse(1);
        step(2'd0, 1'b0, 8'h00, 1'b0, 8'h45);
        step(2'd1, 1'b0, 8'h00, 1'b0, 8'h01);
        step(2'd2, 1'b0, 8'h00, 1'b0, 8'h08);
        step(2'd3, 1'b0, 8'h00, 1'b0, 8'h01);
        exp_bper = 5208; last_bit_cyc = -1;
        idle(400);

        // Simultaneous events: DIV_HI with resync, disable with resync.
        exp_bper = 0;
        step(2'd0, 1'b1, 8'h0C, 1'b0, -1);
        step(2'd1, 1'b1, 8'h00, 1'b1, -1);
        idle(200);
        step(2'd3, 1'b1, 8'h00, 1'b1, -1);
        idle(20);
        step(2'd3, 1'b0, 8'h00, 1'b1, 0);
        step(2'd3, 1'b1, 8'h01, 1'b0, -1);
        idle(100);

        // Randomized writes and resync pulses with small divisors.
        for (int i = 0; i < 15000; i++) begin
            ra  = 2'($urandom_range(0, 3));
            rwe = 1'b0; rwd = 8'h00; rrs = 1'b0;
            if ($urandom_range(0, 99) < 4) begin
                rwe = 1'b1;
                case (ra)
                    2'd0:    rwd = 8'($urandom_range(0, 40));
                    2'd1:    rwd = ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00;
                    2'd2:    rwd = 8'($urandom_range(0, 255));
                    default: rwd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'h01;
                endcase
            end
            if ($urandom_range(0, 49) == 0) rrs = 1'b1;
            step(ra, rwe, rwd, rrs, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
